pattern_serializer_tx: RTL
==========================

Name: pattern_serializer_tx

Overview:
Serial pattern transmitter: accepts a DATA_W-bit word over a valid/ready handshake and shifts it out MSB-first on a 1-bit line, one bit per clock. The word is repeated (in_repeat+1) times, with GAP_CYCLES idle bits after every repetition. It is the source-side block that drives serial pattern streams into the team's Moore sequence detectors.

Parameters:
DATA_W, 8, width of the pattern word (>= 2)
GAP_CYCLES, 2, idle bit-times after each repetition (0 allowed, meaning back-to-back)
IDLE_LEVEL, 1'b0, dout level when no data bit is being driven

Ports:
clk  input  1  clock, all state changes on posedge
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  in_data/in_repeat offered
in_ready  output  1  block can accept a word; high only in IDLE
in_data  input  DATA_W  pattern word, transmitted MSB first
in_repeat  input  4  extra repetitions: 0 = send once, 15 = send 16 times
dout  output  1  serial data, registered
dout_valid  output  1  high while dout carries a data bit, registered
busy  output  1  high in any state other than IDLE
frame_done  output  1  one-cycle pulse after the last bit of the last repetition

Behaviour:
- Reset (asynchronous, any time, including mid-frame): state=IDLE, dout=IDLE_LEVEL, dout_valid=0, busy=0, frame_done=0, in_ready=1. All counters and the shift register are cleared. The frame in progress is abandoned with no partial completion.
- FSM states: IDLE, SHIFT, GAP. Outputs are Moore-style, registered or decoded from state only. No combinational path exists from in_valid to any output.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge k: capture in_data into word_q and shift_q, and capture in_repeat into rep_cnt.
  - At the same edge k: dout<=in_data[DATA_W-1], dout_valid<=1, bit_cnt<=DATA_W-1, state<=SHIFT.
  - The first bit appears in the cycle immediately after the handshake edge (zero added latency).
- SHIFT:
  - in_ready=0.
  - Each edge while bit_cnt>0: shift left, present the next bit on dout, decrement bit_cnt.
  - Edge with bit_cnt==0 (last bit being driven) and rep_cnt>0:
    - rep_cnt decrements.
    - If GAP_CYCLES>0: go to GAP with gap_cnt=GAP_CYCLES-1, dout<=IDLE_LEVEL, dout_valid<=0.
    - If GAP_CYCLES==0: reload shift_q from word_q and drive its MSB on the next cycle, with no bubble.
  - Edge with bit_cnt==0 and rep_cnt==0:
    - frame_done<=1 for exactly one cycle, dout<=IDLE_LEVEL, dout_valid<=0.
    - If GAP_CYCLES>0, go to GAP (trailing gap). Otherwise go to IDLE.
- GAP:
  - dout=IDLE_LEVEL, dout_valid=0.
  - gap_cnt counts down. When it reaches 0: if reps remain, reload word_q and return to SHIFT (MSB on the next cycle); otherwise go to IDLE.
- Timing:
  - A single-repetition frame occupies exactly DATA_W+GAP_CYCLES cycles before in_ready rises.
  - Total frame length = (in_repeat+1)*(DATA_W+GAP_CYCLES) cycles.
- in_valid outside IDLE is ignored. in_data/in_repeat changes after acceptance have no effect on the frame in progress.
- A new handshake may occur on the first IDLE cycle. The trailing gap therefore guarantees GAP_CYCLES idle bits between frames.
- Widths:
  - bit_cnt = $clog2(DATA_W) bits.
  - gap_cnt = $clog2(GAP_CYCLES+1) bits, with a minimum of 1.
  - rep_cnt = 4 bits; decrement only when nonzero, never wraps.

Decomposition:
- Shared package pattern_pkg holds:
  - the state enum typedef (IDLE, SHIFT, GAP, 2-bit encoding);
  - the default IDLE_LEVEL constant;
  - the REPEAT_W=4 constant shared with detector-side blocks.
- One natural sub-module: pattern_shift_reg (parallel load, shift-left, MSB out, reload enable), kept separate so receiver-side blocks can reuse it. The FSM and counters live in the top.

Test Plan:
- Reset then idle: hold rst_n low 3 cycles, release -> dout=0, dout_valid=0, busy=0, in_ready=1; no activity for 20 cycles.
- Single frame, DATA_W=8, GAP_CYCLES=2: in_data=8'hA5, in_repeat=0 -> dout 1,0,1,0,0,1,0,1 with dout_valid=1 for 8 cycles starting the cycle after the handshake; frame_done pulses once; in_ready returns exactly 10 cycles after the handshake.
- Repeat: in_data=8'h05, in_repeat=2 -> three copies of 0,0,0,0,0,1,0,1, each followed by 2 idle bits; 30 cycles total; a single frame_done after the third copy.
- GAP_CYCLES=0 build, in_data=8'hFF, in_repeat=1 -> 16 consecutive dout=1 with dout_valid=1, no bubble; in_ready high on cycle 17.
- Back-pressure: in_valid held high with changing in_data during a frame -> only the first word is sent; the next accepted word is the value present on the first IDLE cycle.
- Mid-frame reset: assert rst_n low after the 4th bit of 8'hA5 -> outputs immediately at reset values; after release, no residual bits and no frame_done; a new handshake transmits cleanly.

Source files
------------

// File: rtl/pattern_serializer_tx_pkg.sv
// Shared types and constants for the pattern serializer and the
// detector-side blocks it feeds.
package pattern_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam logic IDLE_LEVEL_DEF = 1'b0;
  localparam int   REPEAT_W       = 4;

endpackage

// File: rtl/pattern_serializer_tx_if.sv
// Word-offer handshake between a pattern source and the serializer.
interface pattern_serializer_tx_if
  import pattern_pkg::*;
#(
  parameter int DATA_W = 8
);

  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   in_data;
  logic [REPEAT_W-1:0] in_repeat;

  modport master (
    output in_valid,
    output in_data,
    output in_repeat,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_repeat,
    output in_ready
  );

endinterface

// File: rtl/pattern_serializer_tx_shift_reg.sv
// Word holder plus left-shifting register of bits still to be sent;
// reload restarts the word from the held copy.
module pattern_shift_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  input  logic              shift,
  input  logic              reload,
  output logic              next_bit,
  output logic              word_msb
);

  logic [DATA_W-1:0] word_q;
  logic [DATA_W-1:0] shift_q;

  // shift_q omits the MSB, which the caller drives directly on load/reload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q  <= '0;
      shift_q <= '0;
    end else if (load) begin
      word_q  <= d;
      shift_q <= {d[DATA_W-2:0], 1'b0};
    end else if (reload) begin
      shift_q <= {word_q[DATA_W-2:0], 1'b0};
    end else if (shift) begin
      shift_q <= {shift_q[DATA_W-2:0], 1'b0};
    end
  end

  assign next_bit = shift_q[DATA_W-1];
  assign word_msb = word_q[DATA_W-1];

endmodule

// File: rtl/pattern_serializer_tx.sv
// Serial pattern transmitter: MSB-first word, repeated, with idle gaps
// after every repetition.
module pattern_serializer_tx
  import pattern_pkg::*;
#(
  parameter int   DATA_W     = 8,
  parameter int   GAP_CYCLES = 2,
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  pattern_serializer_tx_if.slave   in_if,
  output logic                     dout,
  output logic                     dout_valid,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int BIT_W = $clog2(DATA_W);
  localparam int GAP_W =
    (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD =
    GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_e              state_q, state_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [REPEAT_W-1:0] rep_q, rep_d;
  logic                more_q, more_d;
  logic                dout_d, dv_d, fd_d;
  logic                load, shift, reload;
  logic                next_bit, word_msb;

  pattern_shift_reg #(
    .DATA_W(DATA_W)
  ) u_sr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .d        (in_if.in_data),
    .shift    (shift),
    .reload   (reload),
    .next_bit (next_bit),
    .word_msb (word_msb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_q      <= '0;
      gap_q      <= '0;
      rep_q      <= '0;
      more_q     <= 1'b0;
      dout       <= IDLE_LEVEL;
      dout_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_q      <= bit_d;
      gap_q      <= gap_d;
      rep_q      <= rep_d;
      more_q     <= more_d;
      dout       <= dout_d;
      dout_valid <= dv_d;
      frame_done <= fd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    rep_d   = rep_q;
    more_d  = more_q;
    dout_d  = IDLE_LEVEL;
    dv_d    = 1'b0;
    fd_d    = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
    reload  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_if.in_valid) begin
          load    = 1'b1;
          rep_d   = in_if.in_repeat;
          dout_d  = in_if.in_data[DATA_W-1];
          dv_d    = 1'b1;
          bit_d   = BIT_LAST;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_q != '0) begin
          shift  = 1'b1;
          dout_d = next_bit;
          dv_d   = 1'b1;
          bit_d  = bit_q - BIT_W'(1);
        end else if (rep_q != '0) begin
          rep_d = rep_q - REPEAT_W'(1);
          if (GAP_CYCLES > 0) begin
            gap_d   = GAP_LOAD;
            more_d  = 1'b1;
            state_d = GAP;
          end else begin
            reload = 1'b1;
            dout_d = word_msb;
            dv_d   = 1'b1;
            bit_d  = BIT_LAST;
          end
        end else begin
          fd_d   = 1'b1;
          more_d = 1'b0;
          if (GAP_CYCLES > 0) begin
            gap_d   = GAP_LOAD;
            state_d = GAP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_q != '0) begin
          gap_d = gap_q - GAP_W'(1);
        end else if (more_q) begin
          reload  = 1'b1;
          dout_d  = word_msb;
          dv_d    = 1'b1;
          bit_d   = BIT_LAST;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_if.in_ready = (state_q == IDLE);
  assign busy           = (state_q != IDLE);

endmodule
